// File: rtl/sysid_read_arbiter.sv
// Round-robin arbiter sharing one two-word system-ID slave between two
// Avalon-MM read masters. Repeat reads can be served from a small cache.
module sysid_read_arbiter #(
    parameter int unsigned READ_LATENCY = 0,
    parameter bit          CACHE_EN     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_read,
    input  logic        m0_address,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    input  logic        m1_read,
    input  logic        m1_address,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        slv_address,
    input  logic [31:0] slv_readdata,
    input  logic        cache_flush,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] LATENCY = 4'(READ_LATENCY);

    state_t      r_state;
    state_t      w_nextState;
    logic        r_grant;
    logic        r_lastGrant;
    logic [3:0]  r_cnt;

    logic        w_anyReq;
    logic        w_grantSel;
    logic        w_grantAddr;
    logic        w_hit;
    logic [31:0] w_cacheWord;
    logic        w_enterDone;
    logic        w_doneMaster;
    logic [31:0] w_loadData;

    // Pick the next master, decide hit/miss, and work out what completes next cycle
    always_comb begin
        w_nextState  = r_state;
        w_anyReq     = m0_read | m1_read;
        w_grantSel   = 1'b0;
        w_grantAddr  = 1'b0;
        w_enterDone  = 1'b0;
        w_doneMaster = r_grant;
        w_loadData   = slv_readdata;

        if (m0_read && m1_read) begin
            w_grantSel = ~r_lastGrant;
        end else begin
            w_grantSel = m1_read;
        end
        w_grantAddr = w_grantSel ? m1_address : m0_address;

        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_nextState = w_hit ? DONE : WAIT;
                end
                w_doneMaster = w_grantSel;
                w_loadData   = w_cacheWord;
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        w_enterDone = (w_nextState == DONE) && (r_state != DONE);
    end

    // State register, grant bookkeeping, slave address latch and latency counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grant     <= 1'b0;
            r_lastGrant <= 1'b1;
            r_cnt       <= 4'd0;
            slv_address <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_state <= w_nextState;
            busy    <= (w_nextState != IDLE);
            if (r_state == IDLE && w_anyReq) begin
                r_grant     <= w_grantSel;
                slv_address <= w_grantAddr;
                r_cnt       <= LATENCY;
            end
            if (r_state == WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == DONE) begin
                r_lastGrant <= r_grant;
            end
        end
    end

    // Per-master completion: waitrequest drops and readdata updates only in DONE
    always_ff @(posedge clock) begin
        if (reset) begin
            m0_waitrequest <= 1'b1;
            m1_waitrequest <= 1'b1;
            m0_readdata    <= 32'd0;
            m1_readdata    <= 32'd0;
        end else begin
            m0_waitrequest <= !(w_enterDone && !w_doneMaster);
            m1_waitrequest <= !(w_enterDone &&  w_doneMaster);
            if (w_enterDone && !w_doneMaster) begin
                m0_readdata <= w_loadData;
            end
            if (w_enterDone && w_doneMaster) begin
                m1_readdata <= w_loadData;
            end
        end
    end

    generate
        if (CACHE_EN) begin : g_cache
            logic [31:0] r_cacheData [2];
            logic [1:0]  r_valid;
            logic        w_fill;

            assign w_fill      = (r_state == WAIT) && (r_cnt == 4'd0);
            assign w_hit       = r_valid[w_grantAddr];
            assign w_cacheWord = r_cacheData[w_grantAddr];

            // Valid bits: set on a slave fill, cleared by flush (flush beats a same-cycle fill)
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_valid <= 2'b00;
                end else if (cache_flush) begin
                    r_valid <= 2'b00;
                end else if (w_fill) begin
                    r_valid[slv_address] <= 1'b1;
                end
            end

            // Cached words; contents only matter while the matching valid bit is set
            always_ff @(posedge clock) begin
                if (w_fill) begin
                    r_cacheData[slv_address] <= slv_readdata;
                end
            end
        end else begin : g_noCache
            logic w_unusedFlush;
            assign w_unusedFlush = cache_flush;
            assign w_hit         = 1'b0;
            assign w_cacheWord   = 32'd0;
        end
    endgenerate

endmodule

// File: doc/sysid_read_arbiter.md
Name: sysid_read_arbiter

Overview:
- Shares one read-only, two-word system-ID Avalon-MM slave between two masters: CPU data master (m0) and JTAG/debug master (m1).
- Round-robin arbitration; one transaction in flight at a time.
- Drives the slave address, waits a configurable fixed slave latency, captures the slave data, and completes the transaction with a one-cycle waitrequest release.
- Optional 2-entry result cache: repeat reads of the constant ID/timestamp words complete without touching the slave.

Parameters:
- READ_LATENCY, 0: slave cycles from address registered to readdata valid (0..15).
- CACHE_EN, 1: 1 = per-address result cache enabled; 0 = every read goes to the slave.

Ports:
- clock  in  1  single system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- m0_read  in  1  master 0 read request, held until waitrequest low.
- m0_address  in  1  master 0 word address (0 = ID, 1 = timestamp).
- m0_waitrequest  out  1  low for exactly the completion cycle of m0.
- m0_readdata  out  32  valid in m0 completion cycle.
- m1_read, m1_address, m1_waitrequest, m1_readdata: same as m0, for master 1.
- slv_address  out  1  registered address to the shared slave.
- slv_readdata  in  32  slave read data.
- cache_flush  in  1  one-cycle pulse that clears all cache valid bits.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset values: state IDLE; slv_address 0; m0/m1_readdata 0; m0/m1_waitrequest 1; busy 0; cache valid bits 0; last_grant = 1, so m0 wins the first tie.
- A reset asserted mid-transaction aborts it: no completion cycle, waitrequest stays high, and the master must re-request.
- FSM states: IDLE, WAIT, DONE.
- IDLE, no read pending: stay in IDLE.
- IDLE, read pending:
  - Grant: the single requester, or on a tie the master opposite last_grant.
  - Latch grant and the granted master's address into slv_address.
  - If CACHE_EN and valid[addr]: load the cached word into the data register and go to DONE.
  - Otherwise load cnt = READ_LATENCY and go to WAIT.
- WAIT:
  - cnt != 0: decrement cnt.
  - cnt == 0: capture slv_readdata into the data register and go to DONE.
  - If CACHE_EN, also write cache[slv_address] and set its valid bit.
- DONE:
  - granted master's waitrequest = 0 and its readdata = data register, for exactly one cycle.
  - last_grant <= grant; go to IDLE.
- Latency, with read first seen in IDLE at cycle t:
  - Uncached: completion at cycle t+2+READ_LATENCY.
  - Cache hit: completion at cycle t+1.
  - Minimum spacing between completions: 2 cycles (DONE to IDLE).
- The non-granted master's waitrequest stays 1 throughout; its request is served next (round-robin), so there is no starvation.
- The latched address is used; address changes while waiting are ignored.
- A master that drops read mid-transaction is a protocol violation: the transaction still runs to DONE, and the completion is harmless.
- readdata of a master holds its last completion value between completions.
- cache_flush asserted in the same cycle as a cache fill: flush wins, and the entry is invalid afterwards. The in-flight transaction still returns the slave data.
- CACHE_EN = 0: cache logic absent; every read takes the uncached path.
- busy = (state != IDLE), registered.

Test Plan:
- Reset, then idle 5 cycles -> both waitrequest = 1, readdata = 0, slv_address = 0, busy = 0.
- READ_LATENCY = 2, CACHE_EN = 0; slave model returns 0x00000007 @ addr 0 and 0x527BBC93 @ addr 1; m0 reads addr 1 at cycle t -> m0_waitrequest low only at t+4, m0_readdata = 0x527BBC93.
- m0 and m1 both read addr 0 from reset -> m0 completes first with 0x00000007, m1 completes 2+READ_LATENCY+1 cycles later. A further simultaneous request -> m0 granted again only after m1 (alternation verified over 8 transactions).
- CACHE_EN = 1: m1 reads addr 0 twice -> first completion at t+2+READ_LATENCY, second at t'+1 with no slv_address change. Then pulse cache_flush and read again -> full latency restored.
- Assert reset during WAIT -> next cycle state IDLE, no completion pulse. Re-issue the read -> completes normally with the correct data.
- Change m0_address from 0 to 1 during WAIT -> returned data is 0x00000007 (latched address).
